// File: rtl/ram_fifo8_ctrl.sv
// First-word-fall-through byte FIFO controller driving a 256x8 RAM with 1-cycle read latency.
// Optional level/threshold logic is enabled by defining RAM_FIFO8_LEVEL_EN.
module ram_fifo8_ctrl (
  input  logic       AClkH,
  input  logic       AResetH,
  input  logic       AClkHEn,
  input  logic       AClr,
  input  logic [7:0] AWrData,
  input  logic       AWrReq,
  output logic       AFull,
  output logic [7:0] ARdData,
  output logic       ARdVld,
  input  logic       ARdAck,
  output logic       AOvf,
  output logic [7:0] ARamAddrWr,
  output logic [7:0] ARamAddrRd,
  output logic [7:0] ARamMosi,
  output logic       ARamWrEn,
  input  logic [7:0] ARamMiso,
  input  logic [7:0] AThr,
  output logic [8:0] ALevel,
  output logic       AThrIrq
);

  logic [7:0] wp, rp, la, b0, b1;
  logic [8:0] rc;
  logic [1:0] bo, boAfterPop;
  logic [2:0] pending;
  logic       inFlight, ovf;
  logic       clr, pop, push, fetch, arrive;

  assign clr        = AResetH | AClr;
  assign pop        = ARdAck & (bo != 2'd0) & AClkHEn;
  assign push       = AWrReq & ~AFull & AClkHEn & ~clr;
  // Words already owed to the buffer after this cycle's pop; at most two may be outstanding.
  assign pending    = {1'b0, bo} + {2'b00, inFlight} - {2'b00, pop};
  assign fetch      = (rc != 9'd0) & (pending < 3'd2) & AClkHEn & ~clr;
  assign arrive     = inFlight & AClkHEn;
  assign boAfterPop = bo - {1'b0, pop};

  assign AFull      = rc[8];
  assign ARdVld     = (bo != 2'd0);
  assign ARdData    = b0;
  assign AOvf       = ovf;
  assign ARamAddrWr = wp;
  // Holding the last fetched address keeps ARamMiso stable across disabled cycles.
  assign ARamAddrRd = fetch ? rp : la;
  assign ARamMosi   = AWrData;
  assign ARamWrEn   = push;

  always_ff @(posedge AClkH) begin
    if (clr) begin
      wp       <= 8'd0;
      rp       <= 8'd0;
      la       <= 8'd0;
      rc       <= 9'd0;
      inFlight <= 1'b0;
      bo       <= 2'd0;
      b0       <= 8'd0;
      b1       <= 8'd0;
      ovf      <= 1'b0;
    end else if (AClkHEn) begin
      if (push) wp <= wp + 8'd1;
      if (fetch) begin
        rp <= rp + 8'd1;
        la <= rp;
      end
      inFlight <= fetch;
      rc       <= rc + {8'd0, push} - {8'd0, fetch};
      if (AWrReq & AFull) ovf <= 1'b1;
      bo <= boAfterPop + {1'b0, arrive};
      if (pop) b0 <= b1;
      // Arriving word lands in the first free entry after the pop shift.
      if (arrive) begin
        if (boAfterPop == 2'd0) b0 <= ARamMiso;
        else                    b1 <= ARamMiso;
      end
    end
  end

`ifdef RAM_FIFO8_LEVEL_EN
  logic thrIrq;

  assign ALevel  = rc + {7'd0, bo} + {8'd0, inFlight};
  assign AThrIrq = thrIrq;

  always_ff @(posedge AClkH) begin
    if (AResetH) thrIrq <= 1'b0;
    else if (AClkHEn) thrIrq <= (AThr != 8'd0) & (ALevel >= {1'b0, AThr});
  end
`else
  logic unusedThr;

  assign unusedThr = ^AThr;
  assign ALevel    = 9'd0;
  assign AThrIrq   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo8_ctrl.sv
// Directed bench for ram_fifo8_ctrl with a behavioural 256x8 RAM (1-cycle registered read).
// Level/threshold checks follow RAM_FIFO8_LEVEL_EN.
module tb_ram_fifo8_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, clr, wrReq, rdAck;
  logic [7:0] wrData, thr;
  logic       AFull, ARdVld, AOvf, ARamWrEn, AThrIrq;
  logic [7:0] ARdData, ARamAddrWr, ARamAddrRd, ARamMosi, ramMiso;
  logic [8:0] ALevel;
  logic [7:0] mem [256];

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  ram_fifo8_ctrl dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AClr(clr),
    .AWrData(wrData), .AWrReq(wrReq), .AFull(AFull), .ARdData(ARdData),
    .ARdVld(ARdVld), .ARdAck(rdAck), .AOvf(AOvf), .ARamAddrWr(ARamAddrWr),
    .ARamAddrRd(ARamAddrRd), .ARamMosi(ARamMosi), .ARamWrEn(ARamWrEn),
    .ARamMiso(ramMiso), .AThr(thr), .ALevel(ALevel), .AThrIrq(AThrIrq)
  );

  always @(posedge clk) begin
    if (ARamWrEn) mem[ARamAddrWr] <= ARamMosi;
    ramMiso <= mem[ARamAddrRd];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; clr = 1'b0; en = 1'b1; wrReq = 1'b0; rdAck = 1'b0; thr = 8'd0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b1; wrReq = 1'b1; wrData = 8'h5A; rdAck = 1'b0; thr = 8'd1;
    step(); step();
    nChecks++; if (AFull !== 1'b0) begin nFails++; $display("FAIL reset_full: got %b want 0", AFull); end
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL reset_vld: got %b want 0", ARdVld); end
    nChecks++; if (ARdData !== 8'h00) begin nFails++; $display("FAIL reset_data: got %h want 00", ARdData); end
    nChecks++; if (AOvf !== 1'b0) begin nFails++; $display("FAIL reset_ovf: got %b want 0", AOvf); end
    nChecks++; if (ARamWrEn !== 1'b0) begin nFails++; $display("FAIL reset_wren: got %b want 0", ARamWrEn); end
    nChecks++; if (ARamAddrWr !== 8'h00) begin nFails++; $display("FAIL reset_addrwr: got %h want 00", ARamAddrWr); end
    nChecks++; if (ARamAddrRd !== 8'h00) begin nFails++; $display("FAIL reset_addrrd: got %h want 00", ARamAddrRd); end
    nChecks++; if (ALevel !== 9'd0) begin nFails++; $display("FAIL reset_level: got %0d want 0", ALevel); end
    nChecks++; if (AThrIrq !== 1'b0) begin nFails++; $display("FAIL reset_irq: got %b want 0", AThrIrq); end
    rst = 1'b0; wrReq = 1'b0; thr = 8'd0;
    step();
  endtask

  task automatic test_single_byte();
    wrData = 8'hA5; wrReq = 1'b1;
    step();
    wrReq = 1'b0;
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL single_vld_c1: got %b want 0", ARdVld); end
`ifdef RAM_FIFO8_LEVEL_EN
    nChecks++; if (ALevel !== 9'd1) begin nFails++; $display("FAIL single_level_c1: got %0d want 1", ALevel); end
`endif
    step();
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL single_vld_c2: got %b want 0", ARdVld); end
    step();
    nChecks++; if (ARdVld !== 1'b1) begin nFails++; $display("FAIL single_vld_c3: got %b want 1", ARdVld); end
    nChecks++; if (ARdData !== 8'hA5) begin nFails++; $display("FAIL single_data: got %h want a5", ARdData); end
    rdAck = 1'b1;
    step();
    rdAck = 1'b0;
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL single_vld_after_ack: got %b want 0", ARdVld); end
    nChecks++; if (ALevel !== 9'd0) begin nFails++; $display("FAIL single_level_end: got %0d want 0", ALevel); end
    // A pop while empty changes nothing.
    rdAck = 1'b1;
    step();
    rdAck = 1'b0;
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL single_empty_pop: got %b want 0", ARdVld); end
  endtask

  task automatic test_clock_enable();
    logic [7:0] got [8];
    logic [7:0] want [3];
    int n;
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    doReset();
    wrReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrData = want[i];
      step();
    end
    // Fetch of address 1 is in flight here; freeze the block with another push pending.
    en = 1'b0; wrData = 8'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      nChecks++; if (ARamAddrRd !== 8'h01) begin nFails++; $display("FAIL ce_addrrd[%0d]: got %h want 01", i, ARamAddrRd); end
      nChecks++; if (ARamWrEn !== 1'b0) begin nFails++; $display("FAIL ce_wren[%0d]: got %b want 0", i, ARamWrEn); end
`ifdef RAM_FIFO8_LEVEL_EN
      nChecks++; if (ALevel !== 9'd3) begin nFails++; $display("FAIL ce_level[%0d]: got %0d want 3", i, ALevel); end
`endif
      step();
    end
    en = 1'b1; wrReq = 1'b0; rdAck = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (ARdVld === 1'b1 && n < 8) begin got[n] = ARdData; n++; end
      step();
    end
    rdAck = 1'b0;
    nChecks++; if (n !== 3) begin nFails++; $display("FAIL ce_count: got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (i < n && got[i] !== want[i]) begin nFails++; $display("FAIL ce_data[%0d]: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_stream();
    int n, gaps, bad, firstCyc;
    logic [7:0] wantByte;
    doReset();
    rdAck = 1'b1;
    n = 0; gaps = 0; bad = 0; firstCyc = -1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      wrReq  = (cyc < 600);
      wrData = 8'(cyc);
      if (ARdVld === 1'b1) begin
        if (firstCyc < 0) firstCyc = cyc;
        wantByte = 8'(n);
        nChecks++; if (ARdData !== wantByte) begin nFails++; bad++; if (bad < 5) $display("FAIL stream_data[%0d]: got %h want %h", n, ARdData, wantByte); end
        n++;
      end else if (n > 0 && n < 600) begin
        gaps++;
      end
      step();
    end
    wrReq = 1'b0; rdAck = 1'b0;
    nChecks++; if (firstCyc !== 3) begin nFails++; $display("FAIL stream_first: got cycle %0d want 3", firstCyc); end
    nChecks++; if (n !== 600) begin nFails++; $display("FAIL stream_count: got %0d want 600", n); end
    nChecks++; if (gaps !== 0) begin nFails++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_full_overflow();
    int n, bad;
    logic [7:0] wantByte;
    doReset();
    wrReq = 1'b1;
    for (int i = 0; i < 258; i++) begin
      if (i == 257) begin
        nChecks++; if (AFull !== 1'b0) begin nFails++; $display("FAIL full_early: got %b want 0", AFull); end
      end
      wrData = 8'(i);
      step();
    end
    wrReq = 1'b0;
    nChecks++; if (AFull !== 1'b1) begin nFails++; $display("FAIL full_set: got %b want 1", AFull); end
    nChecks++; if (AOvf !== 1'b0) begin nFails++; $display("FAIL full_ovf_pre: got %b want 0", AOvf); end
    nChecks++; if (ARdVld !== 1'b1 || ARdData !== 8'h00) begin nFails++; $display("FAIL full_head: got %b/%h want 1/00", ARdVld, ARdData); end
`ifdef RAM_FIFO8_LEVEL_EN
    nChecks++; if (ALevel !== 9'd258) begin nFails++; $display("FAIL full_level: got %0d want 258", ALevel); end
`endif
    wrReq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wrData = 8'hEE;
      #1;
      nChecks++; if (ARamWrEn !== 1'b0) begin nFails++; $display("FAIL ovf_wren[%0d]: got %b want 0", i, ARamWrEn); end
      step();
      nChecks++; if (AOvf !== 1'b1) begin nFails++; $display("FAIL ovf_set[%0d]: got %b want 1", i, AOvf); end
    end
    wrReq = 1'b0;
    rdAck = 1'b1;
    step();
    rdAck = 1'b0;
    nChecks++; if (AFull !== 1'b0) begin nFails++; $display("FAIL full_clear: got %b want 0", AFull); end
    nChecks++; if (ARdData !== 8'h01) begin nFails++; $display("FAIL full_head2: got %h want 01", ARdData); end
    // Drain the remaining 257 words; pointers wrap past 255 on the way.
    rdAck = 1'b1;
    n = 0; bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (ARdVld === 1'b1) begin
        wantByte = 8'(n + 1);
        nChecks++; if (ARdData !== wantByte) begin nFails++; bad++; if (bad < 5) $display("FAIL drain_data[%0d]: got %h want %h", n, ARdData, wantByte); end
        n++;
      end
      step();
    end
    rdAck = 1'b0;
    nChecks++; if (n !== 257) begin nFails++; $display("FAIL drain_count: got %0d want 257", n); end
    nChecks++; if (AOvf !== 1'b1) begin nFails++; $display("FAIL ovf_sticky: got %b want 1", AOvf); end
  endtask

  task automatic test_flush();
    int waitCyc;
    wrReq = 1'b1;
    wrData = 8'h51; step();
    wrData = 8'h52; step();
    wrData = 8'h53; step();
    nChecks++; if (ARdVld !== 1'b1) begin nFails++; $display("FAIL flush_pre_vld: got %b want 1", ARdVld); end
    clr = 1'b1; wrData = 8'h77;
    #1;
    nChecks++; if (ARamWrEn !== 1'b0) begin nFails++; $display("FAIL flush_wren: got %b want 0", ARamWrEn); end
    step();
    clr = 1'b0; wrReq = 1'b0;
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL flush_vld: got %b want 0", ARdVld); end
    nChecks++; if (AOvf !== 1'b0) begin nFails++; $display("FAIL flush_ovf: got %b want 0", AOvf); end
    nChecks++; if (ALevel !== 9'd0) begin nFails++; $display("FAIL flush_level: got %0d want 0", ALevel); end
    nChecks++; if (ARamAddrWr !== 8'h00 || ARamAddrRd !== 8'h00) begin nFails++; $display("FAIL flush_addr: got %h/%h want 00/00", ARamAddrWr, ARamAddrRd); end
    step();
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL flush_discard: got %b want 0", ARdVld); end
    wrReq = 1'b1; wrData = 8'h3C;
    step();
    wrReq = 1'b0;
    waitCyc = 0;
    while (ARdVld !== 1'b1 && waitCyc < 8) begin step(); waitCyc++; end
    nChecks++; if (waitCyc !== 2) begin nFails++; $display("FAIL flush_latency: got %0d extra cycles want 2", waitCyc); end
    nChecks++; if (ARdData !== 8'h3C) begin nFails++; $display("FAIL flush_first: got %h want 3c", ARdData); end
    rdAck = 1'b1;
    step();
    rdAck = 1'b0;
    step(); step();
    nChecks++; if (ARdVld !== 1'b0) begin nFails++; $display("FAIL flush_empty: got %b want 0", ARdVld); end
  endtask

`ifdef RAM_FIFO8_LEVEL_EN
  task automatic test_threshold();
    doReset();
    thr = 8'd4; wrReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wrData = 8'(8'hC0 + i);
      step();
    end
    wrReq = 1'b0;
    nChecks++; if (ALevel !== 9'd4) begin nFails++; $display("FAIL thr_level: got %0d want 4", ALevel); end
    nChecks++; if (AThrIrq !== 1'b0) begin nFails++; $display("FAIL thr_irq_pre: got %b want 0", AThrIrq); end
    step();
    nChecks++; if (AThrIrq !== 1'b1) begin nFails++; $display("FAIL thr_irq_set: got %b want 1", AThrIrq); end
    rdAck = 1'b1;
    step();
    rdAck = 1'b0;
    step();
    nChecks++; if (AThrIrq !== 1'b0) begin nFails++; $display("FAIL thr_irq_clr: got %b want 0", AThrIrq); end
    nChecks++; if (ALevel !== 9'd3) begin nFails++; $display("FAIL thr_level_after: got %0d want 3", ALevel); end
    thr = 8'd0;
    step(); step();
    nChecks++; if (AThrIrq !== 1'b0) begin nFails++; $display("FAIL thr_zero: got %b want 0", AThrIrq); end
  endtask
`else
  task automatic test_level_off();
    doReset();
    thr = 8'd1; wrReq = 1'b1; wrData = 8'h99;
    step(); step(); step();
    wrReq = 1'b0;
    step();
    nChecks++; if (ALevel !== 9'd0) begin nFails++; $display("FAIL lvloff_level: got %0d want 0", ALevel); end
    nChecks++; if (AThrIrq !== 1'b0) begin nFails++; $display("FAIL lvloff_irq: got %b want 0", AThrIrq); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; wrReq = 1'b0; rdAck = 1'b0; wrData = 8'h00; thr = 8'd0;
    test_reset();
    test_single_byte();
    test_clock_enable();
    test_stream();
    test_full_overflow();
    test_flush();
`ifdef RAM_FIFO8_LEVEL_EN
    test_threshold();
`else
    test_level_off();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
